// File: rtl/barrel_shifter_pkg.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pkg
//
// Shared definitions for the pipelined barrel shifter/rotator:
//   - operation codes (OP_SRL .. OP_ROL); codes above OP_ROL are reserved
//     and pass the operand through unchanged
//   - is_left(op)       : op runs on the bit-reversed operand (SLL, ROL)
//   - is_rotate(op)     : shifted-out bits are fed back in (ROR, ROL)
//   - is_defined_op(op) : op actually shifts (reserved codes do not)
// ---------------------------------------------------------------------------
package barrel_shifter_pkg;

    localparam logic [2:0] OP_SRL = 3'b000;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic is_rotate(input logic [2:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic is_defined_op(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// ---------------------------------------------------------------------------
// barrel_shift_stage
//
// One level of the right-shift datapath plus its pipeline register.
// When amount bit log2(SHIFT) is set the operand moves right by SHIFT
// positions; the vacated top bits are filled according to the op:
// zeros (SRL/SLL), the entry sign (SRA) or the bits shifted out (rotates).
// Reserved op codes never shift.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both 1. ready_o = ~valid_q | ready_i, so an empty
// stage always accepts (bubbles collapse) and a full stage accepts only
// when its content leaves in the same cycle. A stalled stage holds all
// of its registers unchanged. flush_i clears valid on the next edge and
// wins over any transfer in that cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           kill the op held in this stage
//   valid_i/ready_o   upstream handshake
//   data_i .. tag_i   upstream payload (data, amount, op, sign, tag)
//   valid_o/ready_i   downstream handshake
//   data_o .. tag_o   registered payload towards the next stage
// ---------------------------------------------------------------------------
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int TAG_W  = 4,
    parameter  int SHIFT  = 1,
    localparam int LEVELS = $clog2(WIDTH),
    localparam int BIT    = $clog2(SHIFT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [LEVELS-1:0] amt_i,
    input  logic [2:0]        op_i,
    input  logic              sign_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  data_o,
    output logic [LEVELS-1:0] amt_o,
    output logic [2:0]        op_o,
    output logic              sign_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_d;
    logic [LEVELS-1:0] amt_q;
    logic [2:0]        op_q;
    logic              sign_q;
    logic [TAG_W-1:0]  tag_q;

    logic [SHIFT-1:0]  fill;
    logic [WIDTH-1:0]  shifted;

    // One mux level of the right-shift datapath.
    always_comb begin
        fill = '0;
        if (is_rotate(op_i)) begin
            fill = data_i[SHIFT-1:0];
        end else if (op_i == OP_SRA) begin
            fill = {SHIFT{sign_i}};
        end
        shifted = {fill, data_i[WIDTH-1:SHIFT]};
        data_d  = (amt_i[BIT] && is_defined_op(op_i)) ? shifted : data_i;
    end

    assign ready_o = ~valid_q | ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= OP_SRL;
            sign_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (ready_o) begin
                valid_q <= valid_i;
            end
            // Payload only moves on an accepted transfer; otherwise it holds.
            if (ready_o && valid_i) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                op_q   <= op_i;
                sign_q <= sign_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign op_o    = op_q;
    assign sign_o  = sign_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter/rotator: SRL, SRA, SLL, ROR, ROL on a WIDTH-bit
// operand, one shift level per pipeline stage (LEVELS = log2(WIDTH) stages),
// one op per cycle throughput, sideband tag returned with the result.
// Left ops are turned into right ops by bit-reversing the operand on entry
// and the result on exit. The SRA sign is captured once at entry and
// travels with the op.
//
// Handshake: request accepted on an edge with in_valid & in_ready; result
// consumed on an edge with out_valid & out_ready. in_ready depends
// combinationally on out_ready through the per-stage ready chain; there is
// no other input-to-output combinational path. flush kills every in-flight
// op (and any request offered in the same cycle) on the next edge.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            synchronous kill of all in-flight ops
//   in_valid/in_ready                request handshake
//   in_data, in_amount, in_op, in_tag request payload
//   out_valid/out_ready              result handshake
//   out_data, out_tag                result payload
// ---------------------------------------------------------------------------
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int TAG_W  = 4,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_amount,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    // Index k is the input of stage k; index LEVELS is the pipe output.
    logic              valid_s [LEVELS+1];
    logic [WIDTH-1:0]  data_s  [LEVELS+1];
    logic [LEVELS-1:0] amt_s   [LEVELS+1];
    logic [2:0]        op_s    [LEVELS+1];
    logic              sign_s  [LEVELS+1];
    logic [TAG_W-1:0]  tag_s   [LEVELS+1];

    logic [WIDTH-1:0]  entry_rev;
    logic [WIDTH-1:0]  exit_rev;

    always_comb begin
        entry_rev = '0;
        exit_rev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            entry_rev[i] = in_data[WIDTH-1-i];
            exit_rev[i]  = data_s[LEVELS][WIDTH-1-i];
        end
    end

    // Entry: reverse for left ops, latch the sign for SRA.
    assign valid_s[0] = in_valid;
    assign data_s[0]  = is_left(in_op) ? entry_rev : in_data;
    assign amt_s[0]   = in_amount;
    assign op_s[0]    = in_op;
    assign sign_s[0]  = in_data[WIDTH-1];
    assign tag_s[0]   = in_tag;

    // Each stage keeps its own ready pair so the ready chain stays a set of
    // distinct signals rather than one vector feeding itself.
    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        logic rdy_up;
        logic rdy_dn;

        if (k == LEVELS - 1) begin : g_tail
            assign rdy_dn = out_ready;
        end else begin : g_body
            assign rdy_dn = g_stage[k+1].rdy_up;
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SHIFT (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .valid_i (valid_s[k]),
            .ready_o (rdy_up),
            .data_i  (data_s[k]),
            .amt_i   (amt_s[k]),
            .op_i    (op_s[k]),
            .sign_i  (sign_s[k]),
            .tag_i   (tag_s[k]),
            .valid_o (valid_s[k+1]),
            .ready_i (rdy_dn),
            .data_o  (data_s[k+1]),
            .amt_o   (amt_s[k+1]),
            .op_o    (op_s[k+1]),
            .sign_o  (sign_s[k+1]),
            .tag_o   (tag_s[k+1])
        );
    end

    assign in_ready = g_stage[0].rdy_up;

    // Exit: undo the entry reversal for left ops.
    assign out_valid = valid_s[LEVELS];
    assign out_data  = is_left(op_s[LEVELS]) ? exit_rev : data_s[LEVELS];
    assign out_tag   = tag_s[LEVELS];

    // Amount and sign are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{amt_s[LEVELS], sign_s[LEVELS]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int LV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LV-1:0] in_amount;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard: expected result, tag, acceptance cycle, latency-check flag.
    logic [W-1:0]  exp_q[$];
    logic [TW-1:0] tag_q[$];
    int            cyc_q[$];
    bit            lat_q[$];

    int occ     = 0;
    bit occ_chk = 1'b0;
    bit rdy_rand  = 1'b0;
    bit rdy_fixed = 1'b1;

    task automatic clear_sb();
        exp_q.delete();
        tag_q.delete();
        cyc_q.delete();
        lat_q.delete();
        occ = 0;
    endtask

    // Reference model used for the random stream.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input logic [LV-1:0] a,
                                            input logic [2:0] op);
        logic signed [W-1:0] s;
        logic [W-1:0]        r;
        s = d;
        case (op)
            3'b000:  r = d >> a;
            3'b001:  r = s >>> a;
            3'b010:  r = d << a;
            3'b011:  r = (d >> a) | (d << (W - int'(a)));
            3'b100:  r = (d << a) | (d >> (W - int'(a)));
            default: r = d;
        endcase
        return r;
    endfunction

    // ---------------- consumer ready pattern ----------------
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 1) != 0) : rdy_fixed;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [W-1:0]  e_data;
        logic [TW-1:0] e_tag;
        int            e_cyc;
        bit            e_lat;
        if (rst_n) begin
            if (flush) begin
                clear_sb();
            end else begin
                if (occ_chk) check("in_ready_vs_occupancy", in_ready, !(occ == LV && !out_ready));
                if (in_valid && in_ready) occ++;
                if (out_valid && out_ready) begin
                    occ--;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e_data = exp_q.pop_front();
                        e_tag  = tag_q.pop_front();
                        e_cyc  = cyc_q.pop_front();
                        e_lat  = lat_q.pop_front();
                        check("out_data", out_data, e_data);
                        check("out_tag", out_tag, e_tag);
                        if (e_lat) check("latency", cyc - e_cyc, LV);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [LV-1:0] a, input logic [2:0] op,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp, input bit lat);
        int budget;
        bit done;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_op     = op;
        in_tag    = tag;
        budget    = 0;
        done      = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                tag_q.push_back(tag);
                cyc_q.push_back(cyc);
                lat_q.push_back(lat);
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 200) begin
                    check("send_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < limit) begin
            @(negedge clk);
            b++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);

        // Basic ops, back-to-back, out_ready held high.
        send(16'h8001, 4'd3, 3'b001, 4'h1, 16'hF000, 1'b1);
        send(16'h8001, 4'd3, 3'b000, 4'h2, 16'h1000, 1'b1);
        send(16'h8001, 4'd1, 3'b010, 4'h3, 16'h0002, 1'b1);
        send(16'h0001, 4'd1, 3'b011, 4'h4, 16'h8000, 1'b1);
        send(16'h8001, 4'd4, 3'b100, 4'h5, 16'h0018, 1'b1);
        // Maximum amounts.
        send(16'h8000, 4'd15, 3'b001, 4'h6, 16'hFFFF, 1'b1);
        send(16'h8000, 4'd15, 3'b000, 4'h7, 16'h0001, 1'b1);
        send(16'hFFFF, 4'd15, 3'b010, 4'h8, 16'h8000, 1'b1);
        send(16'h1234, 4'd15, 3'b011, 4'h9, 16'h2468, 1'b1);
        wait_drain(50);

        // Reserved op codes and amount 0.
        send(16'hA5A5, 4'd7, 3'b111, 4'hA, 16'hA5A5, 1'b1);
        send(16'h5A5A, 4'd9, 3'b101, 4'hB, 16'h5A5A, 1'b1);
        send(16'h1234, 4'd0, 3'b000, 4'hC, 16'h1234, 1'b1);
        send(16'hC3C3, 4'd0, 3'b001, 4'hD, 16'hC3C3, 1'b1);
        send(16'h1234, 4'd0, 3'b010, 4'hE, 16'h1234, 1'b1);
        send(16'h1234, 4'd0, 3'b011, 4'hF, 16'h1234, 1'b1);
        send(16'h1234, 4'd0, 3'b100, 4'h0, 16'h1234, 1'b1);
        wait_drain(50);

        // Stall stability and fill.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        send(16'hF0F0, 4'd4, 3'b000, 4'h1, 16'h0F0F, 1'b0);
        send(16'hF0F0, 4'd4, 3'b001, 4'h2, 16'hFF0F, 1'b0);
        send(16'h00FF, 4'd8, 3'b010, 4'h3, 16'hFF00, 1'b0);
        @(negedge clk);
        check("three_in_flight_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(16'h1234, 4'd4, 3'b011, 4'h4, 16'h4123, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, exp_q[0]);
            check("stall_out_tag", out_tag, tag_q[0]);
            check("stall_in_ready", in_ready, 0);
        end
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        wait_drain(50);

        // Random stream with random consumer readiness.
        occ_chk  = 1'b1;
        rdy_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0]  d;
            logic [LV-1:0] a;
            logic [2:0]    op;
            d  = W'($urandom_range(0, 16'hFFFF));
            a  = LV'($urandom_range(0, W - 1));
            op = 3'($urandom_range(0, 7));
            send(d, a, op, TW'(i), ref_op(d, a, op), 1'b0);
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain(300);
        occ_chk = 1'b0;

        // Flush with three ops in flight plus a request in the flush cycle.
        send(16'h1111, 4'd1, 3'b000, 4'h1, 16'h0888, 1'b0);
        send(16'h2222, 4'd2, 3'b010, 4'h2, 16'h8888, 1'b0);
        send(16'h3333, 4'd3, 3'b011, 4'h3, 16'h6666, 1'b0);
        in_valid  = 1'b1;
        in_data   = 16'h4444;
        in_amount = 4'd4;
        in_op     = 3'b000;
        in_tag    = 4'h4;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_output", seen, 0);
        @(posedge clk);
        #1;
        send(16'h0001, 4'd15, 3'b100, 4'h9, 16'h8000, 1'b1);
        wait_drain(50);

        // Asynchronous reset with a full, stalled pipe.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        send(16'hFFFF, 4'd1, 3'b000, 4'h5, 16'h7FFF, 1'b0);
        send(16'hFFFF, 4'd2, 3'b010, 4'h6, 16'hFFFC, 1'b0);
        send(16'h8421, 4'd4, 3'b100, 4'h7, 16'h4218, 1'b0);
        send(16'h8421, 4'd4, 3'b011, 4'h8, 16'h1842, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_out_tag", out_tag, 0);
        check("midreset_in_ready", in_ready, 1);
        clear_sb();
        rdy_fixed = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_pulse", out_valid, 0);
            check("post_reset_in_ready", in_ready, 1);
        end
        @(posedge clk);
        #1;
        send(16'h8001, 4'd3, 3'b001, 4'hB, 16'hF000, 1'b1);
        wait_drain(50);

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter/rotator with valid/ready handshake. It is the multi-cycle successor of the 16-bit combinational shifter and covers logical and arithmetic shifts plus both rotates. It sits on the datapath between operand fetch and writeback and carries a sideband tag so results can be matched to requests. One shift level is registered per pipeline stage, so throughput is one op per cycle at any WIDTH.

## Interface
Parameters:
- WIDTH, 16: data width; must be a power of 2, at least 2.
- TAG_W, 4: sideband tag width; at least 1.
- LEVELS, $clog2(WIDTH): derived, not overridable. It sets the shift-amount width and the pipeline depth.

Ports:
- clk  in  1  : single clock; all flops are rising-edge.
- rst_n  in  1  : asynchronous, active-low reset.
- flush  in  1  : synchronous; kills every in-flight op.
- in_valid  in  1  : request valid.
- in_ready  out  1  : request accepted when in_valid & in_ready.
- in_data  in  WIDTH  : operand.
- in_amount  in  LEVELS  : shift/rotate amount, 0..WIDTH-1.
- in_op  in  3  : operation code (see Operation).
- in_tag  in  TAG_W  : sideband tag, returned unchanged.
- out_valid  out  1  : result valid.
- out_ready  in  1  : consumer ready.
- out_data  out  WIDTH  : result.
- out_tag  out  TAG_W  : tag of the result.

## Operation
- Op codes:
  - 3'b000 SRL: logical right.
  - 3'b001 SRA: arithmetic right, replicating in_data[WIDTH-1].
  - 3'b010 SLL: logical left.
  - 3'b011 ROR: rotate right.
  - 3'b100 ROL: rotate left.
  - 3'b101..3'b111: reserved; the result is in_data unchanged, for any amount.
- Left ops bit-reverse the operand at entry and the result at exit, and run the right-shift datapath in between.
- Fill bits:
  - SRL/SLL fill with 0.
  - SRA fills with the sign bit latched at entry; the sign is carried with the op, not re-read per stage.
  - ROR/ROL feed the bits shifted out back in.
- Stage k (k = 0..LEVELS-1) shifts by 2^k when amount bit k is 1. Each stage registers data, remaining amount bits, op, sign, tag and a valid bit.
- Amount 0 returns in_data unchanged for every op.
- Handshake, per stage:
  - stage_ready[k] = ~valid[k] | stage_ready[k+1]. The last stage uses out_ready; in_ready = stage_ready[0].
  - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
  - A stalled stage holds data, tag and valid unchanged.
  - out_data and out_tag are stable while out_valid & ~out_ready.
  - in_ready may depend combinationally on out_ready. No other input-to-output combinational path exists.
- Flush: all valid bits clear on the next edge. A request accepted in the flush cycle is dropped. in_ready stays 1 during flush. Data registers need not clear.

## Timing
- Reset: all valid bits 0. out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 from reset release.
- Latency: a request accepted at edge N produces out_valid = 1 after edge N+LEVELS-1, so the result is visible for the edge N+LEVELS. With no stall that is LEVELS cycles: 4 for WIDTH = 16.
- Throughput: one op per cycle when out_ready stays 1.
- Capacity: up to LEVELS ops in flight. After out_ready goes low, in_ready falls only once every stage is full.
- Simultaneous in/out transfer in a full pipe is allowed and keeps occupancy constant.
- Reset asserted mid-operation: all in-flight ops are lost immediately (asynchronous). No output pulse on release.
- Flush and reset take priority over any handshake in the same cycle.

## Structure
- Package barrel_shifter_pkg holds:
  - op code localparams OP_SRL, OP_SRA, OP_SLL, OP_ROR, OP_ROL;
  - a function is_left(op) and a function is_rotate(op).
- Sub-module barrel_shift_stage (parameter SHIFT) is instantiated LEVELS times in a generate loop. It contains one level of mux, its pipeline register, and the ready logic.
- The top level contains only entry bit-reversal, sign capture, exit bit-reversal and flush fan-out.

## Test plan
All scenarios use WIDTH = 16.
- Basic ops, out_ready held at 1:
  - SRA 16'h8001 by 3 -> 16'hF000;
  - SRL 16'h8001 by 3 -> 16'h1000;
  - SLL 16'h8001 by 1 -> 16'h0002;
  - ROR 16'h0001 by 1 -> 16'h8000;
  - ROL 16'h8001 by 4 -> 16'h0018.
  - Each result arrives exactly 4 cycles after acceptance.
- Amount 0 and reserved ops: op 3'b111 with 16'hA5A5 by 7 -> 16'hA5A5; any op by 0 -> operand unchanged.
- Back-to-back stream: 100 random ops with a random out_ready pattern. Results must be in order, each tag matched, data equal to a reference model, no loss or duplication. in_ready falls only with 4 ops in flight.
- Stall stability: hold out_ready = 0 for 10 cycles with a result at the output. out_data and out_tag stay constant; the pipe fills to 4, then in_ready = 0.
- Flush: 3 ops in flight plus a new request in the flush cycle. No out_valid follows. The next request (ROL 16'h0001 by 15 -> 16'h8000) completes in 4 cycles.
- Reset mid-stream: drop rst_n asynchronously between edges with the pipe full. out_valid = 0 immediately, outputs are 0, and in_ready = 1 after release.
